// File: rtl/tpu_dma_pkg.sv
// Shared types for the host DMA port arbiter: FSM states and element-size codes.
package tpu_dma_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } dma_arb_state_t;

  typedef logic [1:0] elem_sz_t;

  localparam elem_sz_t ELEM_8       = 2'd0;
  localparam elem_sz_t ELEM_16      = 2'd1;
  localparam elem_sz_t ELEM_32      = 2'd2;
  localparam elem_sz_t ELEM_ILLEGAL = 2'd3;

  // A transfer that tpu_top cannot execute; answered with an error, never started.
  function automatic logic req_is_illegal(input logic len_zero, input elem_sz_t esz);
    return len_zero || (esz == ELEM_ILLEGAL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from last_grant_i+1 modulo N, zero latency.
// No backpressure of its own; the caller decides whether the pick is used.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  int best_d;

  // Distance from last_grant_i+1; the smallest distance among requesters wins.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    best_d        = N;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && (((i + N - 1 - int'(last_grant_i)) % N) < best_d)) begin
        best_d        = (i + N - 1 - int'(last_grant_i)) % N;
        grant_valid_o = 1'b1;
        grant_idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dma_req_arbiter.sv
// Shares the tpu_top host DMA port between NUM_REQ requesters: accept -> start next cycle,
// done/err one cycle after dma_done or timeout; one transfer in flight, hold blocks new grants.
module dma_req_arbiter
  import tpu_dma_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 8,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_dir,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_ub_addr,
  input  logic [NUM_REQ*LEN_W-1:0]    req_length,
  input  logic [NUM_REQ*2-1:0]        req_elem_sz,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [NUM_REQ-1:0]          req_err,
  input  logic                        hold,
  output logic                        dma_start,
  output logic                        dma_dir,
  output logic [ADDR_W-1:0]           dma_ub_addr,
  output logic [LEN_W-1:0]            dma_length,
  output logic [1:0]                  dma_elem_sz,
  input  logic                        dma_done,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        arb_busy,
  output logic                        timeout_flag
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dma_arb_state_t    state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  elem_sz_t          esz_q, esz_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tflag_q, tflag_d;

  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [LEN_W-1:0]  win_len;
  elem_sz_t          win_esz;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i         (req_valid),
    .last_grant_i  (last_q),
    .grant_valid_o (win_vld),
    .grant_idx_o   (win_idx)
  );

  assign win_addr = req_ub_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_len  = req_length[int'(win_idx)*LEN_W +: LEN_W];
  assign win_esz  = req_elem_sz[int'(win_idx)*2 +: 2];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    dir_d     = dir_q;
    addr_d    = addr_q;
    len_d     = len_q;
    esz_d     = esz_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    tflag_d   = tflag_q;
    req_ready = '0;
    req_done  = '0;
    req_err   = '0;
    dma_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hold && win_vld) begin
          req_ready = NUM_REQ'(1) << win_idx;
          grant_d   = win_idx;
          dir_d     = req_dir[win_idx];
          addr_d    = win_addr;
          len_d     = win_len;
          esz_d     = win_esz;
          err_d     = req_is_illegal(win_len == '0, win_esz);
          state_d   = req_is_illegal(win_len == '0, win_esz) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        dma_start = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        // dma_done takes priority over a timeout landing in the same cycle.
        if (dma_done) begin
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          tflag_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        req_done = NUM_REQ'(1) << grant_q;
        req_err  = err_q ? (NUM_REQ'(1) << grant_q) : '0;
        last_d   = grant_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      dir_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      esz_q   <= ELEM_8;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      esz_q   <= esz_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
    end
  end

  assign dma_dir      = dir_q;
  assign dma_ub_addr  = addr_q;
  assign dma_length   = len_q;
  assign dma_elem_sz  = esz_q;
  assign grant_id     = grant_q;
  assign arb_busy     = (state_q != IDLE);
  assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Bench for dma_req_arbiter: random request episodes checked against a transaction timeline model.
module tb_dma_req_arbiter;

  localparam int NR = 3;
  localparam int AW = 8;
  localparam int LW = 16;
  localparam int TO = 20;
  localparam int IW = $clog2(NR);

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_ready, req_dir, req_done, req_err;
  logic [NR*AW-1:0] req_ub_addr;
  logic [NR*LW-1:0] req_length;
  logic [NR*2-1:0]  req_elem_sz;
  logic             hold, dma_start, dma_dir, dma_done, arb_busy, timeout_flag;
  logic [AW-1:0]    dma_ub_addr;
  logic [LW-1:0]    dma_length;
  logic [1:0]       dma_elem_sz;
  logic [IW-1:0]    grant_id;

  dma_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_ub_addr(req_ub_addr), .req_length(req_length), .req_elem_sz(req_elem_sz),
    .req_done(req_done), .req_err(req_err), .hold(hold),
    .dma_start(dma_start), .dma_dir(dma_dir), .dma_ub_addr(dma_ub_addr),
    .dma_length(dma_length), .dma_elem_sz(dma_elem_sz), .dma_done(dma_done),
    .grant_id(grant_id), .arb_busy(arb_busy), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: who was served last and whether a timeout was ever seen.
  int            m_last  = NR - 1;
  bit            m_tflag = 1'b0;
  logic          f_dir  [NR];
  logic [AW-1:0] f_addr [NR];
  logic [LW-1:0] f_len  [NR];
  logic [1:0]    f_esz  [NR];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic int pick(input logic [NR-1:0] v);
    for (int s = 1; s <= NR; s++) begin
      if (v[(m_last + s) % NR]) return (m_last + s) % NR;
    end
    return -1;
  endfunction

  task automatic randomize_fields(input bit allow_illegal);
    for (int i = 0; i < NR; i++) begin
      f_dir[i]  = 1'($urandom_range(0, 1));
      f_addr[i] = AW'($urandom);
      f_len[i]  = LW'($urandom_range(1, 65535));
      f_esz[i]  = 2'($urandom_range(0, 2));
      if (allow_illegal && $urandom_range(0, 5) == 0) f_len[i] = '0;
      if (allow_illegal && $urandom_range(0, 5) == 0) f_esz[i] = 2'd3;
    end
  endtask

  task automatic apply_fields();
    for (int i = 0; i < NR; i++) begin
      req_dir[i]               = f_dir[i];
      req_ub_addr[i*AW +: AW]  = f_addr[i];
      req_length[i*LW +: LW]   = f_len[i];
      req_elem_sz[i*2 +: 2]    = f_esz[i];
    end
  endtask

  // One request episode. done_k: dma_done in the k-th WAIT_DONE cycle (k=0 is two cycles
  // after accept); outside 0..TO-1 it never comes and the timeout must answer instead.
  task automatic episode(input logic [NR-1:0] mask, input int hold_n, input int done_k);
    int            w;
    bit            illegal, exp_err, done_seen;
    logic          e_dir;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_len;
    logic [1:0]    e_esz;
    apply_fields();
    req_valid = mask;
    hold      = 1'b1;
    for (int c = 0; c < hold_n; c++) begin
      dma_done = 1'($urandom_range(0, 1));
      sample();
      check_eq("hold_ready", req_ready, 0);
      check_eq("hold_start", dma_start, 0);
      step();
    end
    dma_done = 1'b0;
    hold     = 1'b0;
    w        = pick(mask);
    sample();
    check_eq("idle_busy", arb_busy, 0);
    if (w < 0) begin
      check_eq("none_ready", req_ready, 0);
      step();
      return;
    end
    check_eq("ready", req_ready, 32'(1) << w);
    e_dir = f_dir[w]; e_addr = f_addr[w]; e_len = f_len[w]; e_esz = f_esz[w];
    illegal = (e_len == 0) || (e_esz == 2'd3);
    step();
    // Scramble inputs and wiggle hold: the in-flight transfer must be unaffected.
    req_ub_addr = (NR*AW)'({$urandom, $urandom});
    req_length  = (NR*LW)'({$urandom, $urandom});
    hold        = 1'($urandom_range(0, 1));
    if (illegal) begin
      sample();
      check_eq("ill_done", req_done, 32'(1) << w);
      check_eq("ill_err", req_err, 32'(1) << w);
      check_eq("ill_start", dma_start, 0);
      step();
    end else begin
      sample();
      check_eq("start", dma_start, 1);
      check_eq("grant_id", grant_id, w);
      check_eq("addr", dma_ub_addr, e_addr);
      check_eq("len", dma_length, e_len);
      check_eq("dir", dma_dir, e_dir);
      check_eq("esz", dma_elem_sz, e_esz);
      check_eq("busy", arb_busy, 1);
      step();
      done_seen = 1'b0;
      for (int k = 0; k < TO && !done_seen; k++) begin
        dma_done = (k == done_k);
        sample();
        check_eq("wait_done", req_done, 0);
        check_eq("wait_start", dma_start, 0);
        check_eq("wait_ready", req_ready, 0);
        check_eq("wait_addr", dma_ub_addr, e_addr);
        step();
        done_seen = (k == done_k);
      end
      dma_done = 1'b0;
      exp_err  = !(done_k >= 0 && done_k < TO);
      if (exp_err) m_tflag = 1'b1;
      sample();
      check_eq("resp_done", req_done, 32'(1) << w);
      check_eq("resp_err", req_err, exp_err ? (32'(1) << w) : 0);
      check_eq("tflag", timeout_flag, m_tflag);
      check_eq("resp_len", dma_length, e_len);
      step();
    end
    m_last = w;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; dma_done = 1'b0; req_valid = '0;
    randomize_fields(1'b0);
    apply_fields();
    step(); step();
    sample();
    check_eq("rst_busy", arb_busy, 0);
    check_eq("rst_start", dma_start, 0);
    check_eq("rst_gid", grant_id, 0);
    check_eq("rst_tflag", timeout_flag, 0);
    check_eq("rst_len", dma_length, 0);
    check_eq("rst_done", req_done, 0);
    rst = 1'b0;
    step();

    // Single legal request; dma_done five cycles after start.
    f_dir[0] = 1'b0; f_addr[0] = 8'h10; f_len[0] = 16'd8; f_esz[0] = 2'd0;
    episode(3'b001, 0, 4);

    // Fairness with two requesters held and immediate done.
    randomize_fields(1'b0);
    for (int i = 0; i < 4; i++) episode(3'b011, 0, 0);

    // Illegal requests: zero length, then element size 3.
    f_len[1] = '0; f_esz[1] = 2'd1;
    episode(3'b010, 0, 0);
    f_len[1] = 16'd4; f_esz[1] = 2'd3;
    episode(3'b010, 0, 0);

    // Timeout, then a good transfer keeps the sticky flag.
    randomize_fields(1'b0);
    episode(3'b001, 0, -1);
    episode(3'b100, 0, 2);

    // Hold for 10 cycles, then done exactly on the timeout cycle.
    episode(3'b001, 10, 1);
    episode(3'b010, 0, TO - 1);

    // Reset mid-transfer: next cycle idle with no done, next grant goes to req0.
    apply_fields();
    req_valid = 3'b110; hold = 1'b0;
    sample();
    check_eq("mrst_ready", req_ready, 32'(1) << pick(3'b110));
    step(); step(); step(); step();
    rst = 1'b1;
    sample();
    check_eq("mrst_in_wait", arb_busy, 1);
    step();
    rst = 1'b0; hold = 1'b1;
    sample();
    check_eq("mrst_busy", arb_busy, 0);
    check_eq("mrst_done", req_done, 0);
    check_eq("mrst_tflag", timeout_flag, 0);
    check_eq("mrst_gid", grant_id, 0);
    step();
    m_last = NR - 1; m_tflag = 1'b0;
    req_valid = 3'b111; hold = 1'b0;
    sample();
    check_eq("mrst_first", req_ready, 1);
    hold = 1'b1;
    step();
    sample();
    check_eq("mrst_hold_no_start", dma_start, 0);
    step();

    // Randomized episodes.
    for (int e = 0; e < 40; e++) begin
      int r, dk;
      logic [NR-1:0] msk;
      randomize_fields(1'b1);
      msk = NR'($urandom_range(0, (1 << NR) - 1));
      r   = $urandom_range(0, 9);
      dk  = (r == 0) ? -1 : (r == 1) ? TO - 1 : $urandom_range(0, 6);
      episode(msk, $urandom_range(0, 3), dk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_req_arbiter.md
# dma_req_arbiter

Shares the single host-side DMA port of `tpu_top` (start/dir/ub_addr/length/elem_sz in, busy/done out) between several requesters, such as the UART command loader and a switch/button-driven pattern loader. The arbiter picks one request at a time by round-robin and issues a single-cycle `dma_start` with stable fields. It then waits for `dma_done` or a timeout and returns a done/error pulse to the owning requester. It sits between the requester blocks and `tpu_top`, inside the Basys3 top-level wrapper.

## Interface
Parameters:
- `NUM_REQ`, default 2, number of requesters (2..4).
- `ADDR_W`, default 8, unified-buffer address width.
- `LEN_W`, default 16, transfer length width.
- `TIMEOUT_CYCLES`, default 65535, maximum cycles to wait for `dma_done`. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester; held until ready.
- `req_ready`  out  NUM_REQ  accept strobe, one-hot or zero.
- `req_dir`  in  NUM_REQ  0 = host→UB, 1 = UB→host.
- `req_ub_addr`  in  NUM_REQ*ADDR_W  packed start addresses, requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_length`  in  NUM_REQ*LEN_W  packed lengths.
- `req_elem_sz`  in  NUM_REQ*2  packed element size: 0 = 8b, 1 = 16b, 2 = 32b, 3 = illegal.
- `req_done`  out  NUM_REQ  one-cycle completion pulse to the owner.
- `req_err`  out  NUM_REQ  one-cycle error pulse; coincides with `req_done`.
- `hold`  in  1  when high, no new grant is issued (for example while `tpu_busy`).
- `dma_start`  out  1  one-cycle start pulse to `tpu_top`.
- `dma_dir`  out  1  latched direction.
- `dma_ub_addr`  out  ADDR_W  latched address.
- `dma_length`  out  LEN_W  latched length.
- `dma_elem_sz`  out  2  latched element size.
- `dma_done`  in  1  completion pulse from `tpu_top`.
- `grant_id`  out  `$clog2(NUM_REQ)`  current or last owner.
- `arb_busy`  out  1  high in any state other than IDLE.
- `timeout_flag`  out  1  sticky; set on any timeout, cleared only by `rst`.

## Operation
The FSM has four states: IDLE → ISSUE → WAIT_DONE → RESP → IDLE.

- **IDLE:**
  - If `!hold` and any `req_valid` is high, pick the winner by round-robin, searching from `last_grant+1` modulo `NUM_REQ`.
  - Assert `req_ready[w]` combinationally in that cycle.
  - At the clock edge, latch the winner's fields into the `dma_*` registers and set `grant_id`.
  - If length == 0 or elem_sz == 3, go to RESP with an error and never pulse `dma_start`. Otherwise go to ISSUE.
- **ISSUE:** `dma_start` = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT_DONE.
- **WAIT_DONE:**
  - The counter increments every cycle.
  - If `dma_done` is seen, go to RESP with no error.
  - If the counter reaches `TIMEOUT_CYCLES`, go to RESP with an error and set `timeout_flag`.
  - If `dma_done` and the timeout occur in the same cycle, `dma_done` wins (no error).
- **RESP:** pulse `req_done[grant_id]`, plus `req_err[grant_id]` if there is an error. Set `last_grant` = `grant_id`. Go to IDLE.

Further rules:
- `dma_done` is ignored outside WAIT_DONE.
- `hold` only blocks new grants; it never aborts a transfer in flight.
- A requester that deasserts `req_valid` before it is granted is simply skipped; the arbiter does not record it.
- The `dma_*` field outputs stay stable from ISSUE until the next grant.

## Timing
- Reset values:
  - State IDLE; all outputs 0; `last_grant` = `NUM_REQ-1`, so requester 0 has first priority.
  - `grant_id` = 0, `timeout_flag` = 0, counter = 0.
- Reset asserted mid-transfer: the next cycle is IDLE with all pulses low. No `req_done` is issued for the aborted request.
- Latency:
  - Accept in cycle 0, `dma_start` in cycle 1.
  - `dma_done` in cycle N gives `req_done` in cycle N+1. The earliest next `req_ready` is cycle N+2.
  - Illegal request: accept in cycle 0, `req_done` + `req_err` in cycle 1, no `dma_start`.
- Timeout: with `dma_start` in cycle 1, the error pulse arrives in cycle `TIMEOUT_CYCLES+2`.
- Throughput: at most one transfer in flight. Back-to-back legal transfers with immediate `dma_done` take a minimum of 4 cycles each.

## Structure
- Package `tpu_dma_pkg` holds:
  - the `dma_arb_state_t` enum (IDLE, ISSUE, WAIT_DONE, RESP);
  - the `elem_sz_t` encoding constants `ELEM_8`, `ELEM_16`, `ELEM_32`, `ELEM_ILLEGAL`.
- Sub-module `rr_arbiter`: combinational round-robin pick.
  - Inputs: request vector, `last_grant`.
  - Outputs: `grant_valid`, `grant_idx`.
  - Reusable elsewhere in the design.
- The FSM, field latches and timeout counter live in `dma_req_arbiter`.

## Test plan
- **Single legal request:** req0, dir 0, addr 0x10, len 8, elem 0.
  - `req_ready[0]` in cycle 0.
  - `dma_start` in cycle 1 with addr 0x10 and len 8.
  - `dma_done` driven 5 cycles later → `req_done[0]` one cycle after it, `req_err` = 0.
- **Fairness:** req0 and req1 held continuously with immediate `dma_done` → grant order 0, 1, 0, 1; no requester is granted twice in a row.
- **Illegal requests:**
  - len = 0 → `req_done[1]` + `req_err[1]` one cycle after accept; `dma_start` never asserted.
  - elem_sz = 3 → same response.
- **Timeout:** `TIMEOUT_CYCLES` = 20, `dma_done` never driven → `req_err[0]` in cycle 22; `timeout_flag` stays 1 through later successful transfers.
- **Hold and done/timeout tie:**
  - `hold` = 1 with req0 valid → no `req_ready` for 10 cycles; grant on the cycle `hold` drops.
  - `dma_done` on the exact timeout cycle → no error.
- **Reset mid-transfer:** `rst` pulsed in WAIT_DONE → IDLE next cycle, no `req_done`; the next grant goes to req0.
